alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised two-stage pipelined ALU, successor to the combinational single-op
//  logic units. It adds opcode selection, result flags and a valid/ready handshake
//  with backpressure. It sits between operand issue logic and a result consumer,
//  and registers every output.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; legal values are powers of two, >= 8
//  SHW    $clog2(WIDTH)  shift-amount width; derived, do not override
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      stage 1 can accept a beat this cycle
//  op         in   4      opcode (see BEHAVIOUR)
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B; the shift amount is B[SHW-1:0]
//  out_valid  out  1      Z and flags are valid
//  out_ready  in   1      consumer accepts the result this cycle
//  Z          out  WIDTH  result
//  zero       out  1      Z == 0
//  carry      out  1      ADD: carry-out; SUB/SLT/SLTU: borrow (A<B unsigned); otherwise 0
//  overflow   out  1      ADD/SUB signed overflow; otherwise 0
//  illegal    out  1      opcode was 11..15
// BEHAVIOUR
//  Opcodes
//   0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB (A-B)
//   6 SLT (signed A<B gives 1, else 0), 7 SLTU (unsigned)
//   8 SLL, 9 SRL, 10 SRA (all by B[SHW-1:0])
//   11-15 illegal: Z=0, zero=1, carry=0, overflow=0, illegal=1
//  Stage 1 (s1)
//   - Registers op/A/B and s1_valid on accept (in_valid & in_ready).
//  Stage 2 (s2)
//   - Computes from s1 and registers Z, flags and s2_valid (= out_valid).
//  Handshake
//   - s2_free  = !out_valid | out_ready
//   - in_ready = !s1_valid | s2_free   (combinational; no combinational path from in_valid)
//   - s1 -> s2 transfer when s1_valid & s2_free.
//   - s1 is cleared when it is drained and no new beat is accepted.
//   - out_valid drops after out_ready if s1 is empty.
//   - Z/flags hold stable while out_valid & !out_ready.
//   - A, B and op are don't-care when the beat is not accepted.
//  Latency
//   - Beat accepted at edge N; out_valid=1 after edge N+1.
//   - Throughput is 1 beat/cycle when out_ready stays high.
//   - Capacity is 2 beats; when both stages are full and out_ready=0, in_ready=0.
//  Simultaneous events
//   - Accept into s1 while s1 drains to s2 in the same cycle is legal.
//   - Output consumed while s2 reloads in the same cycle is legal.
//  Arithmetic
//   - ADD/SUB use a WIDTH+1-bit sum; wrap-around is mod 2^WIDTH.
//   - ADD overflow = (A[msb]==B[msb]) & (Z[msb]!=A[msb]).
//   - SUB overflow = (A[msb]!=B[msb]) & (Z[msb]!=A[msb]).
//   - Shift amounts >= WIDTH cannot occur (amount is masked to SHW bits).
//  Reset
//   - s1_valid, out_valid, Z, zero, carry, overflow, illegal all reset to 0.
//   - in_ready=1 in the first cycle after reset.
//   - Reset mid-operation discards both stages without emitting them.
// TESTING (WIDTH=32)
//  1. AND A=F0F0F0F0 B=FFFF0000, out_ready=1 -> 2 cycles later Z=F0F00000, zero=0.
//     NOR A=0 B=0 -> Z=FFFFFFFF. NOR A=0 B=FFFFFFFF -> Z=0, zero=1.
//  2. ADD 7FFFFFFF+1 -> Z=80000000, overflow=1, carry=0.
//     ADD FFFFFFFF+1 -> Z=0, zero=1, carry=1, overflow=0.
//     SUB 0-1 -> Z=FFFFFFFF, carry=1.
//  3. SLT A=FFFFFFFF B=1 -> Z=1. SLTU same operands -> Z=0.
//     SRA 80000000 by 4 -> F8000000. SLL 1 by 31 -> 80000000.
//     SRL by B=0x23 (amount 3): 0x40 -> Z=0x08.
//  4. Stream 8 beats with out_ready=1 -> 8 results on consecutive cycles, in order.
//     Hold out_ready=0 -> in_ready=0 after 2 accepts; Z stays stable.
//     Release out_ready -> no beat is lost or duplicated.
//  5. op=12 -> illegal=1, Z=0, zero=1.
//     Assert rst with both stages full -> next cycle out_valid=0, in_ready=1.
//     No stale result appears afterwards.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 registers the operand beat, stage 2 registers
// the result and flags. Valid/ready on both sides with two beats of capacity.
module alu_pipe #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             illegal
);

   localparam int MSB = WIDTH - 1;

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] z_q;
   logic             zero_q, carry_q, overflow_q, illegal_q;

   logic s2_free, accept, xfer;

   // Handshake: a beat moves on a side whenever valid & ready are both high at
   // the rising edge. in_ready depends only on registered state and out_ready,
   // never on in_valid; s2 may hand off and reload in the same cycle, and s1 may
   // drain to s2 while taking a new beat in the same cycle.
   assign s2_free  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_free;
   assign accept   = in_valid && in_ready;
   assign xfer     = s1_valid_q && s2_free;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (xfer) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Stage-2 datapath, evaluated from the stage-1 registers.
   logic [WIDTH:0]     sum_w, diff_w;
   logic [SHW-1:0]     shamt;
   logic               slt_s, borrow;
   logic [WIDTH-1:0]   z_c;
   logic               zero_c, carry_c, overflow_c, illegal_c;

   assign sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
   assign diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
   assign borrow = diff_w[WIDTH];
   assign shamt  = s1_b_q[SHW-1:0];
   // Differing signs decide the signed compare directly; equal signs cannot overflow.
   assign slt_s  = (s1_a_q[MSB] != s1_b_q[MSB]) ? s1_a_q[MSB] : diff_w[MSB];

   always_comb begin
      z_c        = '0;
      carry_c    = 1'b0;
      overflow_c = 1'b0;
      illegal_c  = 1'b0;
      case (s1_op_q)
         4'd0: z_c = s1_a_q & s1_b_q;
         4'd1: z_c = s1_a_q | s1_b_q;
         4'd2: z_c = s1_a_q ^ s1_b_q;
         4'd3: z_c = ~(s1_a_q | s1_b_q);
         4'd4: begin
            z_c        = sum_w[WIDTH-1:0];
            carry_c    = sum_w[WIDTH];
            overflow_c = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_w[MSB] != s1_a_q[MSB]);
         end
         4'd5: begin
            z_c        = diff_w[WIDTH-1:0];
            carry_c    = borrow;
            overflow_c = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff_w[MSB] != s1_a_q[MSB]);
         end
         4'd6: begin
            z_c     = {{(WIDTH-1){1'b0}}, slt_s};
            carry_c = borrow;
         end
         4'd7: begin
            z_c     = {{(WIDTH-1){1'b0}}, borrow};
            carry_c = borrow;
         end
         4'd8:  z_c = s1_a_q << shamt;
         4'd9:  z_c = s1_a_q >> shamt;
         4'd10: z_c = $unsigned($signed(s1_a_q) >>> shamt);
         default: illegal_c = 1'b1;
      endcase
      zero_c = (z_c == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (accept) begin
            s1_op_q <= op;
            s1_a_q  <= A;
            s1_b_q  <= B;
         end
         // Results only change on a transfer, so they hold while stalled.
         if (xfer) begin
            z_q        <= z_c;
            zero_q     <= zero_c;
            carry_q    <= carry_c;
            overflow_q <= overflow_c;
            illegal_q  <= illegal_c;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign Z         = z_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32): directed vectors plus a randomized stream
// scored against an arithmetic reference model with an expected-result queue.
module tb_alu_pipe;

   localparam int W  = 32;
   localparam int RW = W + 4;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    op;
   logic [W-1:0]  A, B, Z;
   logic          zero, carry, overflow, illegal;

   int n_chk  = 0;
   int n_pass = 0;
   logic [RW-1:0] exp_q[$];

   alu_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Z(Z),
      .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model: {Z, zero, carry, overflow, illegal} ----------------
   function automatic logic [RW-1:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sa, sb, r;
      longint unsigned ua, ub, ur;
      logic [4:0]      sh;
      logic [W-1:0]    z;
      logic            c, v, ill;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      sh = b[4:0];
      z = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
      case (o)
         4'd0: z = a & b;
         4'd1: z = a | b;
         4'd2: z = a ^ b;
         4'd3: z = ~(a | b);
         4'd4: begin
            ur = ua + ub; z = ur[31:0]; c = (ur > 64'hFFFF_FFFF);
            r = sa + sb; v = (r > SMAX) || (r < SMIN);
         end
         4'd5: begin
            ur = ua - ub; z = ur[31:0]; c = (ua < ub);
            r = sa - sb; v = (r > SMAX) || (r < SMIN);
         end
         4'd6: begin z = {31'b0, sa < sb}; c = (ua < ub); end
         4'd7: begin z = {31'b0, ua < ub}; c = (ua < ub); end
         4'd8: z = a << sh;
         4'd9: z = a >> sh;
         4'd10: begin r = sa >>> sh; z = r[31:0]; end
         default: ill = 1'b1;
      endcase
      return {z, z == '0, c, v, ill};
   endfunction

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One beat with out_ready high; returns at the negedge where its result is visible.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = o; A = a; B = b;
      tick();
      in_valid = 1'b0;
      op = 4'($urandom); A = $urandom; B = $urandom;
      tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1; out_ready = 1'b0;
      op = 4'd4; A = $urandom; B = $urandom;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_chk++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_chk++;
      if ({Z, zero, carry, overflow, illegal} !== '0)
         $display("FAIL reset_result: got %h want 0", {Z, zero, carry, overflow, illegal});
      else n_pass++;
      tick();
   endtask

   task automatic test_logic();
      logic [3:0]    ops  [3] = '{4'd0, 4'd3, 4'd3};
      logic [W-1:0]  as   [3] = '{32'hF0F0F0F0, 32'h0, 32'h0};
      logic [W-1:0]  bs   [3] = '{32'hFFFF0000, 32'h0, 32'hFFFFFFFF};
      logic [RW-1:0] exps [3] = '{{32'hF0F00000, 4'b0000}, {32'hFFFFFFFF, 4'b0000}, {32'h0, 4'b1000}};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         n_chk++;
         if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== exps[i])
            $display("FAIL logic_%0d: got v=%b %h want v=1 %h", i, out_valid, {Z, zero, carry, overflow, illegal}, exps[i]);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_arith();
      logic [3:0]    ops  [3] = '{4'd4, 4'd4, 4'd5};
      logic [W-1:0]  as   [3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0};
      logic [W-1:0]  bs   [3] = '{32'h1, 32'h1, 32'h1};
      logic [RW-1:0] exps [3] = '{{32'h80000000, 4'b0010}, {32'h0, 4'b1100}, {32'hFFFFFFFF, 4'b0100}};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         n_chk++;
         if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== exps[i])
            $display("FAIL arith_%0d: got v=%b %h want v=1 %h", i, out_valid, {Z, zero, carry, overflow, illegal}, exps[i]);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_cmp_shift();
      logic [3:0]    ops  [5] = '{4'd6, 4'd7, 4'd10, 4'd8, 4'd9};
      logic [W-1:0]  as   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h40};
      logic [W-1:0]  bs   [5] = '{32'h1, 32'h1, 32'h4, 32'd31, 32'h23};
      logic [RW-1:0] exps [5] = '{{32'h1, 4'b0000}, {32'h0, 4'b1000}, {32'hF8000000, 4'b0000},
                                  {32'h80000000, 4'b0000}, {32'h8, 4'b0000}};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i]);
         n_chk++;
         if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== exps[i])
            $display("FAIL cmp_shift_%0d: got v=%b %h want v=1 %h", i, out_valid, {Z, zero, carry, overflow, illegal}, exps[i]);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_illegal();
      logic [3:0] ops [3] = '{4'd12, 4'd11, 4'd15};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], $urandom, $urandom);
         n_chk++;
         if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== {32'h0, 4'b1001})
            $display("FAIL illegal_%0d: got v=%b %h want v=1 %h", i, out_valid, {Z, zero, carry, overflow, illegal}, {32'h0, 4'b1001});
         else n_pass++;
      end
      tick();
   endtask

   // 8 back-to-back beats: result of beat k is visible two negedges after it is driven.
   task automatic test_stream();
      logic [RW-1:0] exp_a [8];
      out_ready = 1'b1;
      for (int j = 0; j <= 10; j++) begin
         in_valid = (j < 8);
         op = 4'($urandom_range(0, 10)); A = rand_operand(); B = rand_operand();
         #1;
         if (j < 8) begin
            exp_a[j] = model(op, A, B);
            n_chk++;
            if (in_ready !== 1'b1) $display("FAIL stream_in_ready_%0d: got %b want 1", j, in_ready); else n_pass++;
         end
         n_chk++;
         if (j >= 2 && j <= 9) begin
            if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== exp_a[j-2])
               $display("FAIL stream_result_%0d: got v=%b %h want v=1 %h", j - 2, out_valid,
                        {Z, zero, carry, overflow, illegal}, exp_a[j-2]);
            else n_pass++;
         end else begin
            if (out_valid !== 1'b0) $display("FAIL stream_idle_%0d: got v=%b want 0", j, out_valid); else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [RW-1:0] got;
      exp_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         op = 4'($urandom_range(0, 10)); A = rand_operand(); B = rand_operand();
         #1;
         n_chk++;
         if (in_ready !== (i < 2)) $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, i < 2); else n_pass++;
         if (i >= 2) begin
            n_chk++;
            if (out_valid !== 1'b1 || {Z, zero, carry, overflow, illegal} !== exp_q[0])
               $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h", i, out_valid, {Z, zero, carry, overflow, illegal}, exp_q[0]);
            else n_pass++;
         end
         if (in_ready) exp_q.push_back(model(op, A, B));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (out_valid) begin
            got = {Z, zero, carry, overflow, illegal};
            n_chk++;
            if (exp_q.size() == 0) $display("FAIL bp_extra: got %h want none", got);
            else if (got !== exp_q[0]) $display("FAIL bp_drain: got %h want %h", got, exp_q.pop_front());
            else begin n_pass++; void'(exp_q.pop_front()); end
         end
         tick();
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL bp_lost: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_random();
      logic [RW-1:0] got, hold_v;
      logic          hold_p, want_ready;
      int            extra;
      exp_q.delete();
      hold_p = 1'b0; hold_v = '0; extra = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         op = 4'($urandom_range(0, 15)); A = rand_operand(); B = rand_operand();
         #1;
         got = {Z, zero, carry, overflow, illegal};
         if (hold_p) begin
            n_chk++;
            if (out_valid !== 1'b1 || got !== hold_v)
               $display("FAIL rand_stall_hold: got v=%b %h want v=1 %h", out_valid, got, hold_v);
            else n_pass++;
         end
         want_ready = (exp_q.size() < 2) || out_ready;
         n_chk++;
         if (in_ready !== want_ready) $display("FAIL rand_in_ready: got %b want %b", in_ready, want_ready); else n_pass++;
         hold_p = out_valid && !out_ready;
         hold_v = got;
         if (out_valid && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) $display("FAIL rand_spurious: got %h want none", got);
            else if (got !== exp_q[0]) $display("FAIL rand_result: got %h want %h", got, exp_q.pop_front());
            else begin n_pass++; void'(exp_q.pop_front()); end
         end
         if (in_valid && in_ready) exp_q.push_back(model(op, A, B));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (out_valid) begin
            got = {Z, zero, carry, overflow, illegal};
            n_chk++;
            if (exp_q.size() == 0) $display("FAIL rand_drain_extra: got %h want none", got);
            else if (got !== exp_q[0]) $display("FAIL rand_drain: got %h want %h", got, exp_q.pop_front());
            else begin n_pass++; void'(exp_q.pop_front()); end
         end
         tick();
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL rand_lost: got %0d left want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         op = 4'($urandom_range(0, 10)); A = rand_operand(); B = rand_operand();
         tick();
      end
      in_valid = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL mid_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL mid_reset: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      else n_pass++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         n_chk++;
         if (out_valid !== 1'b0) $display("FAIL mid_stale_%0d: got v=%b want 0", i, out_valid); else n_pass++;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0;
      op = '0; A = '0; B = '0;
      @(negedge clk);
      test_reset();
      test_logic();
      test_arith();
      test_cmp_shift();
      test_illegal();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
